// File: rtl/acc_pipe_pkg.sv
// Shared types and defaults for the acc_pipe accumulator pipeline.
// Optional feature macro used by the top: ACC_PIPE_FLUSH_EN.
package acc_pipe_pkg;

    localparam int OP_W         = 2;
    localparam int DEF_W        = 2;
    localparam int DEF_DEPTH    = 4;
    localparam int DEF_EX_STAGE = 2;

    typedef enum logic [OP_W-1:0] {
        OP_XACC = 2'd0,  // STATE ^ d
        OP_XONE = 2'd1,  // d ^ 1
        OP_LOAD = 2'd2,  // d
        OP_ADD  = 2'd3   // STATE + d, carry dropped
    } op_e;

    // Payload at the default width; other widths use a flat vector of
    // payload_w(W) bits laid out as {op, d}.
    typedef struct packed {
        op_e               op;
        logic [DEF_W-1:0]  d;
    } payload_t;

    function automatic int payload_w(input int w);
        return OP_W + w;
    endfunction

endpackage

// File: rtl/acc_pipe_stage.sv
// One pipeline stage: a valid bit plus a payload register.
// clr drops the valid bit and beats adv; the payload only loads when a valid
// item arrives, so a bubble never turns a stale payload into a valid one.
module acc_pipe_stage #(
    parameter int PW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          adv,
    input  logic          clr,
    input  logic          in_vld,
    input  logic [PW-1:0] in_pl,
    output logic          vld,
    output logic [PW-1:0] pl
);

    // Valid/payload register with reset > clear > advance priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld <= 1'b0;
            pl  <= '0;
        end else if (clr) begin
            vld <= 1'b0;
        end else if (adv) begin
            vld <= in_vld;
            if (in_vld) begin
                pl <= in_pl;
            end
        end
    end

endmodule

// File: rtl/acc_pipe.sv
// In-order accumulator pipeline: DEPTH stages of {op, data}, one STATE
// register updated by the item sitting in stage EX_STAGE.
// Optional feature: define ACC_PIPE_FLUSH_EN to add the flush port.
//
// Handshake: an input item transfers on a rising edge where in_vld & in_rdy;
// an output item transfers on a rising edge where out_vld & out_rdy. out_vld
// never depends on out_rdy; in_rdy = ~(out_vld & ~out_rdy) (and ~flush when
// flush exists), so a stalled output freezes the whole pipe and STATE.
module acc_pipe
    import acc_pipe_pkg::*;
#(
    parameter int W        = DEF_W,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int EX_STAGE = DEF_EX_STAGE
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [W-1:0]   data,
    input  logic [OP_W-1:0] action,
    input  logic           in_vld,
    output logic           in_rdy,
    output logic [W-1:0]   out,
    output logic           out_vld,
    input  logic           out_rdy,
    output logic [W-1:0]   state
`ifdef ACC_PIPE_FLUSH_EN
    ,
    input  logic           flush
`endif
);

    localparam int PW = payload_w(W);

    logic [DEPTH-1:0] v;
    logic [PW-1:0]    p     [DEPTH];
    logic [PW-1:0]    st_in [DEPTH];
    logic [DEPTH-1:0] st_vin;

    logic             stall;
    logic             flush_i;
    logic [W-1:0]     state_q;
    logic [W-1:0]     new_state;
    op_e              ex_op;
    logic [W-1:0]     ex_d;

`ifdef ACC_PIPE_FLUSH_EN
    assign flush_i = flush;
`else
    assign flush_i = 1'b0;
`endif

    assign out_vld = v[DEPTH-1];
    assign out     = p[DEPTH-1][W-1:0];
    assign stall   = out_vld & ~out_rdy;
    assign in_rdy  = ~stall & ~flush_i;
    assign state   = state_q;

    assign ex_op = op_e'(p[EX_STAGE][PW-1:W]);
    assign ex_d  = p[EX_STAGE][W-1:0];

    // Next STATE value produced by the item currently in the execute stage.
    always_comb begin
        new_state = state_q;
        case (ex_op)
            OP_XACC: new_state = state_q ^ ex_d;
            OP_XONE: new_state = ex_d ^ W'(1);
            OP_LOAD: new_state = ex_d;
            OP_ADD:  new_state = state_q + ex_d;
            default: new_state = state_q;
        endcase
    end

    // STATE moves only when a real item leaves the execute stage unstalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= '0;
        end else if (!flush_i && !stall && v[EX_STAGE]) begin
            state_q <= new_state;
        end
    end

    genvar i;
    generate
        for (i = 0; i < DEPTH; i++) begin : g_stage
            if (i == 0) begin : g_first
                assign st_vin[i] = in_vld & in_rdy;
                assign st_in[i]  = {action, data};
            end else if (i == EX_STAGE + 1) begin : g_after_ex
                // Data field becomes the freshly computed STATE value.
                assign st_vin[i] = v[i-1];
                assign st_in[i]  = {p[i-1][PW-1:W], new_state};
            end else begin : g_copy
                assign st_vin[i] = v[i-1];
                assign st_in[i]  = p[i-1];
            end

            acc_pipe_stage #(.PW(PW)) u_stage (
                .clk    (clk),
                .rst    (rst),
                .adv    (~stall),
                .clr    (flush_i),
                .in_vld (st_vin[i]),
                .in_pl  (st_in[i]),
                .vld    (v[i]),
                .pl     (p[i])
            );
        end
    endgenerate

endmodule

// File: tb/tb_acc_pipe.sv
// Directed bench for acc_pipe (W=2, DEPTH=4, EX_STAGE=2).
// Flush scenario is built when ACC_PIPE_FLUSH_EN is defined.
module tb_acc_pipe;

    localparam int W = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] data = '0;
    logic [1:0]   action = 2'd0;
    logic         in_vld = 1'b0;
    logic         in_rdy;
    logic [W-1:0] out;
    logic         out_vld;
    logic         out_rdy = 1'b1;
    logic [W-1:0] state;
`ifdef ACC_PIPE_FLUSH_EN
    logic         flush = 1'b0;
`endif

    int checks   = 0;
    int failures = 0;
    logic [W-1:0] exp_q[$];

    localparam logic [1:0] XACC = 2'd0;
    localparam logic [1:0] XONE = 2'd1;
    localparam logic [1:0] LOAD = 2'd2;
    localparam logic [1:0] ADD  = 2'd3;

    acc_pipe #(.W(2), .DEPTH(4), .EX_STAGE(2)) dut (
        .clk     (clk),
        .rst     (rst),
        .data    (data),
        .action  (action),
        .in_vld  (in_vld),
        .in_rdy  (in_rdy),
        .out     (out),
        .out_vld (out_vld),
        .out_rdy (out_rdy),
        .state   (state)
`ifdef ACC_PIPE_FLUSH_EN
        ,
        .flush   (flush)
`endif
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // scoreboard: every output transfer must match the next expected value
    always @(negedge clk) begin
        logic [W-1:0] e;
        if (!rst && out_vld && out_rdy) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out", {31'd0, out_vld}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("sb_out", {30'd0, out}, {30'd0, e});
            end
        end
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        in_vld = 1'b0;
        repeat (n) tick();
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        in_vld = 1'b0;
        tick();
        tick();
        exp_q.delete();
        rst = 1'b0;
    endtask

    task automatic send(input logic [1:0] op, input logic [W-1:0] d, input logic [W-1:0] expv);
        int n;
        in_vld = 1'b1;
        action = op;
        data   = d;
        n      = 0;
        forever begin
            @(negedge clk);
            if (in_rdy) begin
                exp_q.push_back(expv);
                tick();
                in_vld = 1'b0;
                return;
            end
            tick();
            n++;
            if (n > 50) begin
                check("send_timeout", 32'd1, 32'd0);
                in_vld = 1'b0;
                return;
            end
        end
    endtask

    initial begin
        // reset state
        rst = 1'b1;
        tick();
        @(negedge clk);
        check("rst_out_vld", {31'd0, out_vld}, 32'd0);
        check("rst_out", {30'd0, out}, 32'd0);
        check("rst_state", {30'd0, state}, 32'd0);
        check("rst_in_rdy", {31'd0, in_rdy}, 32'd1);
        do_reset();

        // 1: dependent XACCs, latency DEPTH-1 edges after acceptance
        send(XACC, 2'b01, 2'b01);
        send(XACC, 2'b10, 2'b11);
        tick();
        @(negedge clk);
        check("t1_not_yet", {31'd0, out_vld}, 32'd0);
        tick();
        @(negedge clk);
        check("t1_vld1", {31'd0, out_vld}, 32'd1);
        check("t1_out1", {30'd0, out}, 32'd1);
        tick();
        @(negedge clk);
        check("t1_vld2", {31'd0, out_vld}, 32'd1);
        check("t1_out2", {30'd0, out}, 32'd3);
        check("t1_state", {30'd0, state}, 32'd3);
        idle(3);

        // 2: LOAD 10, XONE 10, ADD 10 (3+2 wraps)
        send(LOAD, 2'b10, 2'b10);
        send(XONE, 2'b10, 2'b11);
        send(ADD,  2'b10, 2'b01);
        idle(6);
        check("t2_state", {30'd0, state}, 32'd1);

        // 3: bubble in the middle, no duplicate valid
        do_reset();
        send(XACC, 2'b01, 2'b01);
        idle(1);
        send(XACC, 2'b01, 2'b00);
        tick();
        @(negedge clk);
        check("t3_vld_a", {31'd0, out_vld}, 32'd1);
        tick();
        @(negedge clk);
        check("t3_vld_b", {31'd0, out_vld}, 32'd0);
        tick();
        @(negedge clk);
        check("t3_vld_c", {31'd0, out_vld}, 32'd1);
        check("t3_out_c", {30'd0, out}, 32'd0);
        idle(4);
        check("t3_state", {30'd0, state}, 32'd0);

        // 4: full pipe, downstream stalls for 3 edges
        do_reset();
        send(LOAD, 2'b01, 2'b01);
        send(ADD,  2'b01, 2'b10);
        send(ADD,  2'b01, 2'b11);
        send(ADD,  2'b01, 2'b00);
        out_rdy = 1'b0;
        in_vld  = 1'b1;
        action  = ADD;
        data    = 2'b01;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("t4_in_rdy", {31'd0, in_rdy}, 32'd0);
            check("t4_out_vld", {31'd0, out_vld}, 32'd1);
            check("t4_out", {30'd0, out}, 32'd1);
            check("t4_state", {30'd0, state}, 32'd1);
            tick();
        end
        out_rdy = 1'b1;
        send(ADD, 2'b01, 2'b01);
        idle(8);
        check("t4_state_end", {30'd0, state}, 32'd1);

        // 5: reset drops three in-flight items
        send(LOAD, 2'b11, 2'b11);
        send(XONE, 2'b00, 2'b01);
        send(ADD,  2'b01, 2'b10);
        rst = 1'b1;
        tick();
        @(negedge clk);
        check("t5_out_vld", {31'd0, out_vld}, 32'd0);
        check("t5_out", {30'd0, out}, 32'd0);
        check("t5_state", {30'd0, state}, 32'd0);
        exp_q.delete();
        rst = 1'b0;
        idle(6);
        check("t5_state_idle", {30'd0, state}, 32'd0);

`ifdef ACC_PIPE_FLUSH_EN
        // 6: flush clears two in-flight items, STATE untouched
        do_reset();
        send(LOAD, 2'b11, 2'b11);
        idle(4);
        in_vld = 1'b1;
        action = XACC;
        data   = 2'b01;
        tick();
        tick();
        in_vld = 1'b0;
        tick();
        flush  = 1'b1;
        in_vld = 1'b1;
        action = ADD;
        @(negedge clk);
        check("t6_in_rdy", {31'd0, in_rdy}, 32'd0);
        tick();
        flush  = 1'b0;
        in_vld = 1'b0;
        @(negedge clk);
        check("t6_out_vld", {31'd0, out_vld}, 32'd0);
        check("t6_state", {30'd0, state}, 32'd3);
        idle(6);
        check("t6_state_end", {30'd0, state}, 32'd3);
`endif

        check("drain", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
